ext_mem_responder: RTL and testbench

EXT_MEM_RESPONDER -- requirements
Module: ext_mem_responder

---
 rtl/ext_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_ext_mem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_responder.sv
// ext_mem_responder
//   Wait-state memory responder in front of a 4096 x 32 backing array that
//   covers a 16 KB window starting at BASE_ADDR (bits 13:0 of BASE_ADDR are
//   ignored). Each word waits WAIT_CYCLES+1 cycles, then is offered for one
//   cycle with extNotReady low. The word is consumed at the next rising edge.
//
//   Optional feature: define EXT_MEM_RESP_BURST_EN to stream the rest of a
//   64-byte line at one word per cycle after the first word.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   reset        synchronous, active-high reset
//   extAddr      initiator byte address; word index is extAddr[13:2]
//   extData      read data from the responder, write data from the initiator
//   extOE        initiator read request / output enable
//   extWR        initiator write request (wins over extOE)
//   extHold      initiator busy flag (no functional effect)
//   extNotReady  registered; 0 means the current word is consumed next edge
//   extFault     registered one-cycle pulse on an out-of-window word
module ext_mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [47:0] BASE_ADDR   = 48'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] extAddr,
  inout  wire  [31:0] extData,
  input  logic        extOE,
  input  logic        extWR,
  input  logic        extHold,
  output logic        extNotReady,
  output logic        extFault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RDY  = 2'd2
  } stateT;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  stateT       state_r;
  stateT       nextState_s;
  logic [3:0]  cnt_r;
  logic [3:0]  nextCnt_s;
  logic [31:0] rdata_r;
  logic [11:0] wordIdx_r;
  logic        wordOow_r;
  logic [31:0] mem_r [0:4095];

  logic        reqActive_s;
  logic        addrOow_s;
  logic        loadWord_s;
  logic [11:0] loadIdx_s;
  logic        loadOow_s;
  logic        memWe_s;
  logic        nextNotReady_s;
  logic        nextFault_s;
  logic        driveEn_s;
  logic        unusedBits_s;

  assign reqActive_s  = extOE | extWR;
  assign addrOow_s    = (extAddr[47:14] != BASE_ADDR[47:14]);
  assign unusedBits_s = ^{extHold, extAddr[1:0]};

  // Bus is driven only while a pure read word is on offer; a write never sees
  // the responder on extData.
  assign driveEn_s = (state_r == RDY) & extOE & ~extWR;
  assign extData   = driveEn_s ? rdata_r : 32'bz;

  // Next-state, word-load and registered-output decode.
  always_comb begin
    nextState_s    = state_r;
    nextCnt_s      = cnt_r;
    loadWord_s     = 1'b0;
    loadIdx_s      = wordIdx_r;
    loadOow_s      = wordOow_r;
    memWe_s        = 1'b0;
    nextNotReady_s = 1'b1;
    nextFault_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (reqActive_s) begin
          nextState_s = WAIT;
          nextCnt_s   = WAIT_LOAD;
        end else begin
          nextState_s = IDLE;
        end
      end
      WAIT: begin
        if (!reqActive_s) begin
          nextState_s = IDLE;
        end else if (cnt_r == 4'd0) begin
          // Address is captured only here, so it may wander during WAIT.
          nextState_s    = RDY;
          loadWord_s     = ~extWR;
          loadIdx_s      = extAddr[13:2];
          loadOow_s      = addrOow_s;
          nextNotReady_s = 1'b0;
          nextFault_s    = addrOow_s;
        end else begin
          nextCnt_s = cnt_r - 4'd1;
        end
      end
      RDY: begin
        if (!reqActive_s) begin
          nextState_s = IDLE;
        end else begin
          memWe_s = extWR & ~wordOow_r;
`ifdef EXT_MEM_RESP_BURST_EN
          if (wordIdx_r[3:0] != 4'hF) begin
            // Stream the next word of the same 64-byte line.
            nextState_s    = RDY;
            loadWord_s     = 1'b1;
            loadIdx_s      = wordIdx_r + 12'd1;
            loadOow_s      = wordOow_r;
            nextNotReady_s = 1'b0;
            nextFault_s    = wordOow_r;
          end else begin
            nextState_s = WAIT;
            nextCnt_s   = WAIT_LOAD;
          end
`else
          nextState_s = WAIT;
          nextCnt_s   = WAIT_LOAD;
`endif
        end
      end
      default: begin
        nextState_s = IDLE;
        nextCnt_s   = 4'd0;
      end
    endcase
  end

  // Control state, word pointer, read data and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      rdata_r     <= 32'd0;
      wordIdx_r   <= 12'd0;
      wordOow_r   <= 1'b0;
      extNotReady <= 1'b1;
      extFault    <= 1'b0;
    end else begin
      state_r     <= nextState_s;
      cnt_r       <= nextCnt_s;
      extNotReady <= nextNotReady_s;
      extFault    <= nextFault_s;
      if (nextState_s == RDY && state_r == WAIT) begin
        wordIdx_r <= loadIdx_s;
        wordOow_r <= loadOow_s;
      end else if (loadWord_s) begin
        wordIdx_r <= loadIdx_s;
        wordOow_r <= loadOow_s;
      end
      if (loadWord_s) begin
        rdata_r <= loadOow_s ? 32'hFFFF_FFFF : mem_r[loadIdx_s];
      end
    end
  end

  // Backing array write port; contents survive reset, and a reset edge
  // aborts any write on offer.
  always_ff @(posedge clk) begin
    if (memWe_s && !reset) begin
      mem_r[wordIdx_r] <= extData;
    end
  end

endmodule

// File: tb/tb_ext_mem_responder.sv
module tb_ext_mem_responder;

  localparam int          W    = 2;
  localparam logic [47:0] BASE = 48'h0;
`ifdef EXT_MEM_RESP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] extAddr;
  logic        extOE;
  logic        extWR;
  logic        extHold;
  logic        extNotReady;
  logic        extFault;
  wire  [31:0] extData;
  logic [31:0] tbData;
  logic        tbDrive;

  assign extData = tbDrive ? tbData : 32'bz;

  always #5 clk = ~clk;

  ext_mem_responder #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .extAddr(extAddr), .extData(extData),
    .extOE(extOE), .extWR(extWR), .extHold(extHold),
    .extNotReady(extNotReady), .extFault(extFault)
  );

  typedef struct {
    logic        isRead;
    logic [31:0] data;
    logic        fault;
  } expT;

  expT         expQ[$];
  expT         monE;
  logic [31:0] model [0:4095];
  int          vectors = 0;
  int          miscompares = 0;
  int          cycCount = 0;

  always @(posedge clk) cycCount <= cycCount + 1;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic busFree(input logic [31:0] v);
    return (v === 32'bz) || (v === 32'h0);
  endfunction

  // Monitor: every word on offer with a live request is compared to the
  // oldest expectation; the fault flag may only be high alongside a word.
  always @(negedge clk) begin
    if (!reset) begin
      if (extNotReady) begin
        check("fault_without_word", 48'(extFault), 48'd0);
      end
      if (!extNotReady && (extOE || extWR)) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: actual data %0h, required no word", extData);
        end else begin
          monE = expQ.pop_front();
          check(monE.isRead ? "read_data" : "write_bus", 48'(extData), 48'(monE.data));
          check("fault_flag", 48'(extFault), 48'(monE.fault));
        end
      end
    end
  end

  // Present one word and record what the responder must show for it.
  task automatic issueWord(input logic [47:0] a, input logic isWr, input logic alsoOE,
                           input logic [31:0] wd, input logic commit);
    expT         e;
    logic        oow;
    logic [11:0] idx;
    idx     = a[13:2];
    oow     = (a[47:14] != BASE[47:14]);
    extAddr = a;
    extWR   = isWr;
    extOE   = !isWr || alsoOE;
    extHold = 1'($urandom_range(0, 1));
    tbData  = wd;
    tbDrive = isWr;
    e.isRead = !isWr;
    e.fault  = oow;
    if (isWr) begin
      e.data = wd;
      if (!oow && commit) model[idx] = wd;
    end else begin
      e.data = oow ? 32'hFFFF_FFFF : model[idx];
    end
    expQ.push_back(e);
  endtask

  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!extNotReady) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic idleBus();
    extOE   = 1'b0;
    extWR   = 1'b0;
    tbDrive = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // Sequential multi-word transfer; latency measured from the edge that
  // samples the request (first word) or consumes the previous word.
  task automatic doTile(input logic [47:0] base, input int n, input logic isWr,
                        input logic alsoOE, input logic [31:0] wbase,
                        input logic randData, output int tileCycles);
    int          refCyc;
    int          startCyc;
    int          expLat;
    bit          ok;
    logic [47:0] a;
    logic [31:0] wd;
    refCyc   = cycCount + 1;
    startCyc = refCyc;
    expLat   = W + 1;
    for (int i = 0; i < n; i++) begin
      a  = base + 48'(4 * i);
      wd = randData ? $urandom : wbase + 32'(i);
      issueWord(a, isWr, alsoOE, wd, 1'b1);
      waitReady(ok);
      if (!ok) begin
        vectors++;
        miscompares++;
        $display("FAIL ready_timeout: word at %0h never offered", a);
        expQ.delete();
        break;
      end
      check("latency", 48'(cycCount - refCyc), 48'(expLat));
      @(posedge clk); #1;
      refCyc = cycCount;
      expLat = (BURST && a[5:2] != 4'hF) ? 0 : W + 1;
    end
    tileCycles = cycCount - startCyc;
    idleBus();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    bit   ok;
    int   op;
    int   st;
    int   n;
    logic [47:0] a;

    reset = 1'b1; extAddr = 48'h0; extOE = 1'b0; extWR = 1'b0;
    extHold = 1'b0; tbData = 32'h0; tbDrive = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_notready", 48'(extNotReady), 48'd1);
    check("reset_fault", 48'(extFault), 48'd0);
    check("reset_bus_free", 48'(busFree(extData)), 48'd1);
    @(posedge clk); #1;

    // Preload words 0..63 with A000_0000+k over the bus.
    for (int t = 0; t < 4; t++) begin
      doTile(48'(64 * t), 16, 1'b1, 1'b0, 32'hA000_0000 + 32'(16 * t), 1'b0, cyc);
    end

    // 16-word read tile at 0x40 with full tile timing.
    doTile(48'h40, 16, 1'b0, 1'b0, 32'h0, 1'b0, cyc);
    check("tile_cycles", 48'(cyc), BURST ? 48'(W + 2 + 15) : 48'(16 * (W + 2)));

    // Write tile then read back.
    doTile(48'h80, 16, 1'b1, 1'b0, 32'h5555_0000, 1'b0, cyc);
    doTile(48'h80, 16, 1'b0, 1'b0, 32'h0, 1'b0, cyc);

    // Read and write requested together behave as a write.
    doTile(48'hC0, 4, 1'b1, 1'b1, 32'h1234_0000, 1'b0, cyc);
    doTile(48'hC0, 4, 1'b0, 1'b0, 32'h0, 1'b0, cyc);

    // Out-of-window read, dropped write, in-window word untouched.
    doTile(48'h0001_0000_0000, 1, 1'b0, 1'b0, 32'h0, 1'b0, cyc);
    doTile(48'h0001_0000_0000, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, cyc);
    doTile(48'h0, 1, 1'b0, 1'b0, 32'h0, 1'b0, cyc);

    // extOE dropped during WAIT releases everything.
    extAddr = 48'h44; extOE = 1'b1; extWR = 1'b0; tbDrive = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    extOE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_notready", 48'(extNotReady), 48'd1);
    check("abort_bus_free", 48'(busFree(extData)), 48'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_stays_idle", 48'(extNotReady), 48'd1);
    end
    @(posedge clk); #1;

    // Address wanders during WAIT; only the value at sampling time counts.
    issueWord(48'h14, 1'b0, 1'b0, 32'h0, 1'b1);
    extAddr = 48'h24;
    @(posedge clk); #1;
    extAddr = 48'h14;
    waitReady(ok);
    check("decoy_ready", 48'(ok), 48'd1);
    @(posedge clk); #1;
    idleBus();

    // Reset while a write word is on offer: no array update, back to IDLE.
    issueWord(48'hE0, 1'b1, 1'b0, 32'hBAD0_0001, 1'b0);
    waitReady(ok);
    check("rst_write_ready", 48'(ok), 48'd1);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; extOE = 1'b0; extWR = 1'b0; tbDrive = 1'b0;
    @(negedge clk);
    check("rst_mid_notready", 48'(extNotReady), 48'd1);
    check("rst_mid_fault", 48'(extFault), 48'd0);
    #1;
    doTile(48'hE0, 1, 1'b0, 1'b0, 32'h0, 1'b0, cyc);

    // Randomized tiles against the reference model.
    for (int r = 0; r < 40; r++) begin
      op = $urandom_range(0, 3);
      st = $urandom_range(0, 63);
      n  = $urandom_range(1, (64 - st) < 8 ? (64 - st) : 8);
      if (op == 3) begin
        a = (48'($urandom_range(1, 1000)) << 14) | 48'(4 * st);
        doTile(a, $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b1, cyc);
      end else begin
        doTile(48'(4 * st), n, op != 0, op == 2, 32'h0, 1'b1, cyc);
      end
    end

    check("queue_drained", 48'(expQ.size()), 48'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
